// File: rtl/nibble_pair_gen.sv
// nibble_pair_gen: enumerates every {hi, lo} nibble pair whose sum equals a
// target. Pairs are streamed over valid/ready, one word per cycle when the
// sink is ready. In no-carry mode only pairs with hi + lo < 2^W are produced.
module nibble_pair_gen #(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [W-1:0]   target,
    input  logic           no_wrap,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] doubleNibble,
    output logic           out_last,
    output logic           busy,
    output logic [W:0]     pair_count
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    localparam logic [W-1:0] HiOne  = 1;
    localparam logic [W:0]   CntOne = 1;

    state_e           state_q, state_d;
    logic [W-1:0]     t_q, t_d;
    logic             nw_q, nw_d;
    logic [W-1:0]     hi_q, hi_d;
    logic             valid_q, valid_d;
    logic [2*W-1:0]   dn_q, dn_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic [W:0]       cnt_q, cnt_d;
    logic [W-1:0]     hi_nxt;

    // Final hi of a job: all-ones in modular mode, the target itself in
    // no-carry mode (any larger hi would force lo to wrap).
    function automatic logic is_last(input logic [W-1:0] hi, input logic [W-1:0] t,
                                     input logic nw);
        return nw ? (hi == t) : (hi == {W{1'b1}});
    endfunction

    assign hi_nxt = hi_q + HiOne;

    // Next-state: job accept, per-handshake advance, abort and job completion.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        nw_d    = nw_q;
        hi_d    = hi_q;
        valid_d = valid_q;
        dn_d    = dn_q;
        last_d  = last_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                // abort wins over a simultaneous start request
                if (start_valid && !abort) begin
                    state_d = StEmit;
                    t_d     = target;
                    nw_d    = no_wrap;
                    hi_d    = '0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    dn_d    = {{W{1'b0}}, target};
                    last_d  = is_last('0, target, no_wrap);
                end
            end
            StEmit: begin
                // out_valid is always high here, so out_ready alone is the handshake
                if (out_ready) begin
                    cnt_d = cnt_q + CntOne;
                end
                if (abort || (out_ready && last_q)) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (out_ready) begin
                    hi_d   = hi_nxt;
                    dn_d   = {hi_nxt, t_q - hi_nxt};
                    last_d = is_last(hi_nxt, t_q, nw_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            t_q     <= '0;
            nw_q    <= 1'b0;
            hi_q    <= '0;
            valid_q <= 1'b0;
            dn_q    <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            nw_q    <= nw_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
            dn_q    <= dn_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign start_ready  = (state_q == StIdle);
    assign out_valid    = valid_q;
    assign doubleNibble = dn_q;
    assign out_last     = last_q;
    assign busy         = busy_q;
    assign pair_count   = cnt_q;

endmodule

// File: tb/tb_nibble_pair_gen.sv
// Self-checking bench for nibble_pair_gen: expected words are queued when a
// job is started and popped on each output handshake.
module tb_nibble_pair_gen;

    logic       clk;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] target;
    logic       no_wrap;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] doubleNibble;
    logic       out_last;
    logic       busy;
    logic [4:0] pair_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] sb[$];  // {last, hi, lo}

    nibble_pair_gen #(.W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .target       (target),
        .no_wrap      (no_wrap),
        .abort        (abort),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .doubleNibble (doubleNibble),
        .out_last     (out_last),
        .busy         (busy),
        .pair_count   (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_job(input logic [3:0] t, input logic nw);
        int last_hi;
        logic [3:0] hh;
        logic [3:0] lo;
        last_hi = nw ? int'(t) : 15;
        for (int h = 0; h <= last_hi; h++) begin
            hh = h[3:0];
            lo = t - hh;
            sb.push_back({(h == last_hi), hh, lo});
        end
    endtask

    // Starts a job at a negedge and drains it; optional random backpressure,
    // a start pulse mid-job, and an abort once abort_at handshakes are done.
    task automatic run_job(input logic [3:0] t, input logic nw, input bit rnd,
                           input bit pulse, input int abort_at,
                           output int iters, output int vcycles);
        int hs;
        bit done;
        bit aborted;
        bit prev_stall;
        logic [7:0] prev_dn;
        logic prev_last;
        logic [4:0] prev_cnt;
        logic [8:0] exp;
        logic [3:0] sum4;
        logic [4:0] sum5;
        int len;

        len = nw ? int'(t) + 1 : 16;
        check("start_ready_idle", start_ready, 1);
        start_valid = 1'b1;
        target      = t;
        no_wrap     = nw;
        push_job(t, nw);
        @(negedge clk);
        start_valid = 1'b0;
        target      = ~t;
        hs = 0; iters = 0; vcycles = 0; done = 0; aborted = 0; prev_stall = 0;
        prev_dn = '0; prev_last = 1'b0; prev_cnt = '0;
        for (int c = 0; c < 400 && !done; c++) begin
            iters++;
            if (prev_stall) begin
                check("stall_word", doubleNibble, prev_dn);
                check("stall_last", out_last, prev_last);
                check("stall_count", pair_count, prev_cnt);
            end
            check("pair_count_run", pair_count, hs);
            if (out_valid) vcycles++;
            if (abort_at >= 0 && hs == abort_at) begin
                out_ready = 1'b0;
                abort     = 1'b1;
                @(negedge clk);
                abort     = 1'b0;
                out_ready = 1'b1;
                aborted   = 1;
                done      = 1;
            end else begin
                if (pulse && c == 3) begin
                    start_valid = 1'b1;
                    target      = 4'h0;
                    no_wrap     = 1'b0;
                    check("start_ready_busy", start_ready, 0);
                end else begin
                    start_valid = 1'b0;
                end
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid && out_ready) begin
                    check("sb_nonempty", (sb.size() != 0), 1);
                    exp = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
                    check("word", doubleNibble, exp[7:0]);
                    check("last", out_last, exp[8]);
                    sum4 = doubleNibble[7:4] + doubleNibble[3:0];
                    check("device_sum", sum4, t);
                    if (nw) begin
                        sum5 = {1'b0, doubleNibble[7:4]} + {1'b0, doubleNibble[3:0]};
                        check("no_carry", sum5, {1'b0, t});
                    end
                    hs++;
                    if (out_last) done = 1;
                end
                prev_stall = out_valid && !out_ready;
                prev_dn    = doubleNibble;
                prev_last  = out_last;
                prev_cnt   = pair_count;
                @(negedge clk);
            end
        end
        start_valid = 1'b0;
        out_ready   = 1'b1;
        check("job_done", done, 1);
        check("end_valid", out_valid, 0);
        check("end_last", out_last, 0);
        check("end_busy", busy, 0);
        check("end_start_ready", start_ready, 1);
        if (aborted) begin
            check("end_count_abort", pair_count, abort_at);
            sb.delete();
        end else begin
            check("end_count", pair_count, len);
            check("sb_empty", sb.size(), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int it;
        int vc;
        rst = 1'b1; start_valid = 1'b0; target = '0; no_wrap = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_word", doubleNibble, 0);
        check("rst_last", out_last, 0);
        check("rst_count", pair_count, 0);
        check("rst_busy", busy, 0);
        check("rst_start_ready", start_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Modular mode, 16 back-to-back words
        run_job(4'h3, 1'b0, 0, 0, -1, it, vc);
        check("t1_iters", it, 16);
        check("t1_valid_cycles", vc, 16);

        // No-carry mode, including the single-pair target 0
        run_job(4'h2, 1'b0 | 1'b1, 0, 0, -1, it, vc);
        check("t2_iters", it, 3);
        run_job(4'h0, 1'b1, 0, 0, -1, it, vc);
        check("t2_single", it, 1);

        // Random backpressure with an ignored start pulse mid-job
        run_job(4'hf, 1'b1, 1, 1, -1, it, vc);

        // Abort after 5 handshakes, then a clean job
        run_job(4'h7, 1'b0, 0, 0, 5, it, vc);
        run_job(4'h1, 1'b0, 0, 0, -1, it, vc);

        // Async reset mid-job, checked before the next clock edge
        start_valid = 1'b1; target = 4'h5; no_wrap = 1'b0;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_word", doubleNibble, 0);
        check("arst_count", pair_count, 0);
        check("arst_busy", busy, 0);
        check("arst_start_ready", start_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", out_valid, 0);
        run_job(4'h9, 1'b0, 0, 0, -1, it, vc);

        // Loopback sweep over all targets in both modes
        for (int tt = 0; tt < 16; tt++) begin
            for (int m = 0; m < 2; m++) begin
                run_job(tt[3:0], m[0], 0, 0, -1, it, vc);
                check("sweep_len", it, m[0] ? tt + 1 : 16);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
